button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Conditions the raw FPGA push-button ahead of the reset generator: 2-FF synchroniser,
//  symmetric debounce, one-cycle press/release pulses, optional long-press detect.
//  but_n drives the reset generator's fpga_but1 input (low = pressed, stable, glitch-free).
// PARAMETERS
//  CLK_HZ         10_000_000  clk frequency in Hz
//  DEBOUNCE_MS    20          level must be stable this long; DEB_CYC = CLK_HZ/1000*DEBOUNCE_MS (>=1)
//  LONG_PRESS_MS  2000        hold time for long_press; LP_CYC = CLK_HZ/1000*LONG_PRESS_MS (>DEB_CYC)
//  BUT_ACTIVE_LOW 1           1: but_raw low = pressed; 0: but_raw high = pressed
// PORTS
//  clk            in   1  system clock, rising edge
//  reset          in   1  asynchronous, active-low reset
//  but_raw        in   1  raw button pin, asynchronous to clk, bouncing
//  but_n          out  1  debounced level, low = pressed
//  press_pulse    out  1  one-cycle pulse when a press is accepted
//  release_pulse  out  1  one-cycle pulse when a release is accepted
//  long_press     out  1  one-cycle pulse after LP_CYC cycles of accepted hold (macro only)
// BEHAVIOUR
//  - reset low: sync FFs = released level, state IDLE, counters 0; but_n=1, pulses=0, long_press=0.
//  - pressed_s = 2nd sync FF output normalised to active-high per BUT_ACTIVE_LOW.
//  - All outputs registered; pulses and but_n change on the same edge as the state transition.
//  - FSM (cnt width $clog2(DEB_CYC+1)):
//    IDLE:         pressed_s -> PRESS_WAIT, cnt<=0.
//    PRESS_WAIT:   !pressed_s -> IDLE (bounce discarded, no pulse); else cnt++;
//                  cnt==DEB_CYC-1 && pressed_s -> PRESSED, but_n<=0, press_pulse<=1.
//    PRESSED:      !pressed_s -> RELEASE_WAIT, cnt<=0.
//    RELEASE_WAIT: pressed_s -> PRESSED (bounce, but_n stays 0, no pulse); else cnt++;
//                  cnt==DEB_CYC-1 && !pressed_s -> IDLE, but_n<=1, release_pulse<=1.
//  - Latency: raw change held stable -> but_n/pulse updated on edge DEB_CYC+3 (2 sync + 1 entry).
//  - Any glitch shorter than DEB_CYC cycles (post-sync) never changes but_n nor emits a pulse.
//  - press_pulse and release_pulse never both 1 in one cycle; always strictly alternate, press first.
//  - reset asserted mid-debounce or mid-hold: immediate return to reset values; no pulse emitted.
//    After release of reset a still-held button is re-debounced from IDLE (new press_pulse).
// CONFIGURATION
//  BUTTON_LONG_PRESS_EN defined: hold_cnt ($clog2(LP_CYC+1) bits) <=0 on PRESS_WAIT->PRESSED,
//    increments in PRESSED and RELEASE_WAIT, saturates at LP_CYC; long_press pulses once on the
//    edge hold_cnt goes LP_CYC-1 -> LP_CYC, i.e. LP_CYC edges after but_n fell. No re-pulse until
//    next accepted press. Release bounce back to PRESSED does not clear hold_cnt.
//  Not defined: hold_cnt absent, long_press tied 0.
// STRUCTURE
//  gm64_input_pkg: typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;
//    function ms_to_cycles(int hz, int ms) used for DEB_CYC and LP_CYC.
//  Sub-module sync_2ff (param RST_VAL): 2-stage synchroniser, async active-low reset; reusable
//    for other asynchronous pins. Remainder (FSM, counters) inline in button_debounce.
// TESTING  (bench params CLK_HZ=1000, DEBOUNCE_MS=4, LONG_PRESS_MS=20 -> DEB_CYC=4, LP_CYC=20)
//  1 reset low, but_raw toggling -> but_n=1, pulses=0 throughout; release reset, raw=1 -> no pulses.
//  2 raw 1->0 held -> but_n=0 and press_pulse=1 for exactly one cycle on edge 7 after the change.
//  3 raw low pulses of 1,2,3 cycles separated by 5 cycles high -> but_n stays 1, no press_pulse.
//  4 pressed, then raw high 2 cycles, low 2 cycles, high held -> single release_pulse on edge 7
//    after final rise; no extra press_pulse.
//  5 (EN) hold 30 cycles after press accepted -> one long_press pulse 20 edges after but_n fell;
//    release at 15 cycles -> no long_press. (no EN) long_press constant 0.
//  6 reset asserted 2 cycles after press accepted -> but_n=1 asynchronously, no release_pulse;
//    reset released with raw held low -> new press_pulse on edge 7.

Source files
------------

// File: rtl/gm64_input_pkg.sv
// Shared types and helpers for the board input-conditioning blocks.
package gm64_input_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Millisecond interval to clock cycles, never less than one cycle.
  function automatic int ms_to_cycles(int hz, int ms);
    int c;
    c = hz / 1000 * ms;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for a single asynchronous pin; both stages reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchroniser, symmetric debounce FSM, press/release pulses.
// Define BUTTON_LONG_PRESS_EN to build the long_press hold detector; otherwise long_press is 0.
module button_debounce
  import gm64_input_pkg::*;
#(
  parameter int CLK_HZ         = 10_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_PRESS_MS  = 2000,
  parameter int BUT_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic but_raw,
  output logic but_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int             DEB_CYC  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int             LP_CYC   = ms_to_cycles(CLK_HZ, LONG_PRESS_MS);
  localparam int             CW       = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0]  DEB_LAST = CW'(DEB_CYC - 1);
  localparam logic           REL_LVL  = (BUT_ACTIVE_LOW != 0);

  if (LP_CYC <= DEB_CYC) begin : g_lp_chk
    $error("button_debounce: long-press time must exceed debounce time");
  end

  btn_state_t    state;
  logic [CW-1:0] cnt;
  logic          but_sync;
  logic          pressed_s;
  logic          accept_press;

  // Synchroniser idles at the released pin level so reset never looks like a press.
  sync_2ff #(.RST_VAL(REL_LVL)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (but_raw),
    .q     (but_sync)
  );

  assign pressed_s    = (BUT_ACTIVE_LOW != 0) ? ~but_sync : but_sync;
  assign accept_press = (state == PRESS_WAIT) && pressed_s && (cnt == DEB_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      but_n         <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pressed_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed_s) begin
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            state       <= PRESSED;
            but_n       <= 1'b0;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!pressed_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to pressed keeps the level; nothing was ever reported.
          if (pressed_s) begin
            state <= PRESSED;
          end else if (cnt == DEB_LAST) begin
            state         <= IDLE;
            but_n         <= 1'b1;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int            HW      = $clog2(LP_CYC + 1);
  localparam logic [HW-1:0] LP_MAX  = HW'(LP_CYC);
  localparam logic [HW-1:0] LP_LAST = HW'(LP_CYC - 1);

  logic [HW-1:0] hold_cnt;

  // Hold time runs through release bounces and saturates, so one pulse per accepted press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (accept_press) begin
        hold_cnt <= '0;
      end else if ((state == PRESSED || state == RELEASE_WAIT) && hold_cnt != LP_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == LP_LAST) long_press <= 1'b1;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: vector table plus hand sequences, pulses scored against a queue.
module tb_button_debounce;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic but_raw = 1'b1;
  logic but_n, press_pulse, release_pulse, long_press;

  button_debounce #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_PRESS_MS(20), .BUT_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .but_raw(but_raw), .but_n(but_n),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Raw change driven at the negedge after edge c is reported on edge c+DEB_CYC+3.
  localparam int LAT = 7;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_PRESS, EV_REL, EV_LONG} ev_kind_t;
  typedef struct { ev_kind_t kind; int at; } ev_t;
  typedef struct {
    logic     raw;
    int       hold;
    logic     want_but_n;
    bit       has_ev;
    ev_kind_t kind;
  } vec_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic string kname(ev_kind_t k);
    case (k)
      EV_PRESS: return "press_pulse";
      EV_REL:   return "release_pulse";
      default:  return "long_press";
    endcase
  endfunction

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(ev_kind_t k, int at);
    ev_t e;
    e.kind = k;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic take(ev_kind_t k);
    int idx = -1;
    foreach (exp_q[i]) if (idx < 0 && exp_q[i].kind == k && exp_q[i].at == cyc) idx = i;
    n_cmp++;
    if (idx < 0) begin
      n_bad++;
      $display("FAIL unexpected_%s: got pulse at cyc %0d, want none", kname(k), cyc);
    end else begin
      exp_q.delete(idx);
    end
  endtask

  // Scoreboard side: every pulse must match a queued expectation on its exact cycle.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_%s: got no pulse, want pulse at cyc %0d", kname(exp_q[i].kind), exp_q[i].at);
        exp_q.delete(i);
      end
    end
    if (press_pulse)   take(EV_PRESS);
    if (release_pulse) take(EV_REL);
    if (long_press)    take(EV_LONG);
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(string name);
    tick(LAT + 2);
    check(name, exp_q.size(), 0);
  endtask

  vec_t tbl[14];
  int   c;

  initial begin
    tbl[0]  = '{1'b0, 12, 1'b0, 1'b1, EV_PRESS};  // clean press
    tbl[1]  = '{1'b1,  2, 1'b0, 1'b0, EV_PRESS};  // release bounce
    tbl[2]  = '{1'b0,  2, 1'b0, 1'b0, EV_PRESS};
    tbl[3]  = '{1'b1, 12, 1'b1, 1'b1, EV_REL};    // final rise held
    tbl[4]  = '{1'b0,  1, 1'b1, 1'b0, EV_PRESS};  // 1..4 cycle glitches
    tbl[5]  = '{1'b1,  5, 1'b1, 1'b0, EV_PRESS};
    tbl[6]  = '{1'b0,  2, 1'b1, 1'b0, EV_PRESS};
    tbl[7]  = '{1'b1,  5, 1'b1, 1'b0, EV_PRESS};
    tbl[8]  = '{1'b0,  3, 1'b1, 1'b0, EV_PRESS};
    tbl[9]  = '{1'b1,  5, 1'b1, 1'b0, EV_PRESS};
    tbl[10] = '{1'b0,  4, 1'b1, 1'b0, EV_PRESS};
    tbl[11] = '{1'b1,  6, 1'b1, 1'b0, EV_PRESS};
    tbl[12] = '{1'b0,  5, 1'b1, 1'b1, EV_PRESS};  // shortest accepted press, pulse lands later
    tbl[13] = '{1'b1, 12, 1'b1, 1'b1, EV_REL};

    // Reset held with a toggling pin: outputs pinned at reset values.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      but_raw = ~but_raw;
      check("rst_but_n", but_n, 1);
      check("rst_press", press_pulse, 0);
      check("rst_release", release_pulse, 0);
    end
    @(negedge clk);
    but_raw = 1'b1;
    reset   = 1'b1;
    tick(10);
    check("idle_but_n", but_n, 1);

    foreach (tbl[i]) begin
      but_raw = tbl[i].raw;
      if (tbl[i].has_ev) expect_ev(tbl[i].kind, cyc + LAT);
      tick(tbl[i].hold);
      check($sformatf("vec%0d_but_n", i), but_n, tbl[i].want_but_n);
    end
    drain("vec_pending");

    // Long hold: long_press lands LP_CYC edges after but_n fell.
    c = cyc;
    but_raw = 1'b0;
    expect_ev(EV_PRESS, c + LAT);
`ifdef BUTTON_LONG_PRESS_EN
    expect_ev(EV_LONG, c + LAT + 20);
`endif
    tick(LAT + 30);
    check("long_but_n", but_n, 0);
    but_raw = 1'b1;
    expect_ev(EV_REL, cyc + LAT);
    drain("long_pending");

    // Release accepted 15 edges after the press: too short for long_press.
    c = cyc;
    but_raw = 1'b0;
    expect_ev(EV_PRESS, c + LAT);
    tick(15);
    but_raw = 1'b1;
    expect_ev(EV_REL, cyc + LAT);
    tick(30);
    check("short_pending", exp_q.size(), 0);

    // Reset two edges after a press is accepted, then re-debounce the held button.
    c = cyc;
    but_raw = 1'b0;
    expect_ev(EV_PRESS, c + LAT);
    tick(LAT + 2);
    check("pre_rst_but_n", but_n, 0);
    #2 reset = 1'b0;
    #1 check("async_rst_but_n", but_n, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("held_rst_but_n", but_n, 1);
    end
    reset = 1'b1;
    expect_ev(EV_PRESS, cyc + LAT);
    tick(12);
    check("repress_but_n", but_n, 0);
    but_raw = 1'b1;
    expect_ev(EV_REL, cyc + LAT);
    drain("rst_pending");
    check("final_but_n", but_n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    n_bad++;
    $display("FAIL watchdog: got no end of test by time %0t, want finish", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
